dt_gen: RTL and testbench
=========================

Name: dt_gen

Overview:
- Parametrised dead-time generator for one complementary half-bridge leg.
- Takes a single PWM command and produces high-side (HS) and low-side (LS) gate enables. Both gates are held off for a programmable number of clocks at every transition.
- Dead time comes from a select code through a parametrised linear table. The table generalises the fixed 2..20 clock selector.
- Sits between the PWM modulator and the gate-driver outputs.

Parameters:
- SEL_W, 4, width of the dead-time select code.
- DT_W, 5, width of the dead-time value and counter. Must hold DT_MIN + DT_STEP*SEL_MAX.
- DT_MIN, 2, dead time in clocks for code 0 and for out-of-range codes. Must be ≥ 1.
- DT_STEP, 2, dead-time increment per code step.
- SEL_MAX, 9, highest valid select code.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  leg enable. 0 forces both gates off.
- i_pwm  input  1  PWM command. 1 = HS on, 0 = LS on.
- i_sel  input  SEL_W  dead-time select code.
- o_hs  output  1  high-side gate enable (registered).
- o_ls  output  1  low-side gate enable (registered).
- o_dt  output  DT_W  dead-time value latched for the current/last interval.
- o_busy  output  1  high while a dead-time interval is running.

Behaviour:
- Table: dt = DT_MIN + DT_STEP*i_sel when i_sel ≤ SEL_MAX, else DT_MIN. Compute at 32 bits, then truncate to DT_W.
- Reset (async, i_rst_n=0): state OFF, o_hs=0, o_ls=0, o_dt=DT_MIN, o_busy=0, counter=0.
- States: OFF, DT_H (both off, heading to HS), HS_ON, DT_L (both off, heading to LS), LS_ON.
- All outputs are registered and decoded from the next state: o_hs=1 only in HS_ON, o_ls=1 only in LS_ON, o_busy=1 in DT_H/DT_L.
- Entering DT_H or DT_L loads counter=dt and o_dt=dt from the current i_sel. o_dt changes only at these instants, so a mid-interval i_sel change has no effect until the next transition.
- HS_ON with i_pwm=0 sampled at edge k: o_hs=0 from edge k, o_ls=1 from edge k+dt. Both gates are low for exactly dt cycles. LS_ON→HS_ON is symmetric.
- DT_H/DT_L: counter decrements each cycle. At counter==1, move to the target ON state.
- Short pulse: if i_pwm returns to the previous level during DT_L (or DT_H), return directly to HS_ON (or LS_ON) on that edge. No dead time is inserted because the opposite switch never turned on.
- OFF with i_en=1: enter DT_H if i_pwm=1, DT_L if i_pwm=0, with a full dt interval.
- i_en=0 sampled in any state: go to OFF on that edge, so both gates are low the next cycle. The counter is cleared, o_dt holds its value, and o_busy=0.
- Invariant: o_hs & o_ls is never 1 in any cycle, including reset assertion/deassertion and i_en toggling.
- i_pwm is assumed synchronous to i_clk. Synchronisation is the upstream block's job.

Decomposition:
- Package dt_pkg holds:
  - the state enum (OFF, DT_H, HS_ON, DT_L, LS_ON);
  - default parameter constants (DT_MIN_DEF=2, DT_STEP_DEF=2, SEL_MAX_DEF=9);
  - a function for the sel→dt mapping, shared with the bench model.
- One sub-module, dt_lut: a purely combinational i_sel→dt table using the same parameters, instantiated once in dt_gen.

Test Plan:
- Reset: hold i_rst_n=0 with i_pwm toggling → o_hs=0, o_ls=0, o_dt=2, o_busy=0. After release with i_en=1, i_pwm=1, i_sel=0 → o_hs=1 after exactly 2 both-off cycles.
- Dead-time sweep: i_sel=0..9, square-wave i_pwm with period 64 → both-off gap measures 2,4,…,20 cycles on both edges. o_dt matches each value.
- Out-of-range: i_sel=12 and i_sel=15 → gap = 2 cycles, o_dt=2.
- Short pulse: i_sel=9 (dt=20), HS_ON, i_pwm low for 5 cycles → o_ls never asserts. o_hs re-asserts on the edge after i_pwm returns to 1.
- Mid-interval sel change: i_sel=3 at fall edge, changed to 7 three cycles later → current gap = 8. Next transition gap = 16.
- Enable drop: i_en=0 during DT_L and during LS_ON → both outputs 0 next cycle, o_busy=0. On re-enable, full dt before the first gate asserts. Bench checks o_hs&o_ls==0 every cycle across all scenarios.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared types and constants for the half-bridge dead-time generator.
package dt_pkg;

  localparam int unsigned SEL_W_DEF   = 4;
  localparam int unsigned DT_W_DEF    = 5;
  localparam int unsigned DT_MIN_DEF  = 2;
  localparam int unsigned DT_STEP_DEF = 2;
  localparam int unsigned SEL_MAX_DEF = 9;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DT_H,
    ST_HS_ON,
    ST_DT_L,
    ST_LS_ON
  } dt_state_e;

  // Linear select-to-dead-time map; out-of-range codes fall back to the minimum.
  function automatic int unsigned dt_map(input int unsigned sel,
                                         input int unsigned dt_min,
                                         input int unsigned dt_step,
                                         input int unsigned sel_max);
    return (sel <= sel_max) ? (dt_min + dt_step * sel) : dt_min;
  endfunction

endpackage

// File: rtl/dt_gen_if.sv
// Command/status bundle between the PWM modulator side and the dead-time generator.
interface dt_gen_if #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DT_W  = 5
);

  logic             i_en;
  logic             i_pwm;
  logic [SEL_W-1:0] i_sel;
  logic             o_hs;
  logic             o_ls;
  logic [DT_W-1:0]  o_dt;
  logic             o_busy;

  modport master (
    output i_en, i_pwm, i_sel,
    input  o_hs, o_ls, o_dt, o_busy
  );

  modport slave (
    input  i_en, i_pwm, i_sel,
    output o_hs, o_ls, o_dt, o_busy
  );

endinterface

// File: rtl/dt_lut.sv
// Combinational select-code to dead-time table.
module dt_lut
  import dt_pkg::*;
#(
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DT_W    = DT_W_DEF,
  parameter int unsigned DT_MIN  = DT_MIN_DEF,
  parameter int unsigned DT_STEP = DT_STEP_DEF,
  parameter int unsigned SEL_MAX = SEL_MAX_DEF
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [DT_W-1:0]  dt_c_o
);

  assign dt_c_o = DT_W'(dt_map(32'(sel_i), DT_MIN, DT_STEP, SEL_MAX));

endmodule

// File: rtl/dt_gen.sv
// Dead-time generator for one complementary half-bridge leg: turns a PWM command
// into non-overlapping high-side/low-side gate enables with a programmable gap.
module dt_gen
  import dt_pkg::*;
#(
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DT_W    = DT_W_DEF,
  parameter int unsigned DT_MIN  = DT_MIN_DEF,
  parameter int unsigned DT_STEP = DT_STEP_DEF,
  parameter int unsigned SEL_MAX = SEL_MAX_DEF
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  dt_gen_if.slave  bus
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic [DT_W-1:0] dt_c;
  logic            hs_q, hs_d;
  logic            ls_q, ls_d;
  logic            busy_q, busy_d;
  logic            dt_state_c;

  dt_lut #(
    .SEL_W   (SEL_W),
    .DT_W    (DT_W),
    .DT_MIN  (DT_MIN),
    .DT_STEP (DT_STEP),
    .SEL_MAX (SEL_MAX)
  ) u_lut (
    .sel_i  (bus.i_sel),
    .dt_c_o (dt_c)
  );

  // Next state, counter and output decode; outputs follow the next state so
  // both gates drop on the same edge that leaves an ON state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dt_d    = dt_q;

    unique case (state_q)
      ST_OFF:   state_d = bus.i_pwm ? ST_DT_H : ST_DT_L;
      ST_DT_H: begin
        if (!bus.i_pwm)                 state_d = ST_LS_ON;
        else if (cnt_q == DT_W'(1))     state_d = ST_HS_ON;
      end
      ST_HS_ON: if (!bus.i_pwm)         state_d = ST_DT_L;
      ST_DT_L: begin
        if (bus.i_pwm)                  state_d = ST_HS_ON;
        else if (cnt_q == DT_W'(1))     state_d = ST_LS_ON;
      end
      ST_LS_ON: if (bus.i_pwm)          state_d = ST_DT_H;
      default:                          state_d = ST_OFF;
    endcase

    if (!bus.i_en) state_d = ST_OFF;

    dt_state_c = (state_d == ST_DT_H) || (state_d == ST_DT_L);

    // Fresh interval latches the table value; an ongoing one just counts down.
    if (dt_state_c) begin
      if (state_d != state_q) begin
        cnt_d = dt_c;
        dt_d  = dt_c;
      end else begin
        cnt_d = cnt_q - DT_W'(1);
      end
    end

    hs_d   = (state_d == ST_HS_ON);
    ls_d   = (state_d == ST_LS_ON);
    busy_d = dt_state_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      dt_q    <= DT_W'(DT_MIN);
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dt_q    <= dt_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_hs   = hs_q;
  assign bus.o_ls   = ls_q;
  assign bus.o_dt   = dt_q;
  assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_dt_gen.sv
// Scoreboard bench for dt_gen: expected gate-on events are queued as stimulus is
// driven and retired when a gate rises; gate exclusivity is checked every cycle.
module tb_dt_gen;

  typedef struct {
    int unsigned gap;
    int unsigned dt;
    bit          hs;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  exp_t sb_q[$];

  int unsigned gap_cnt;
  bit          hs_p, ls_p, rise_hs, rise_ls;
  exp_t        e;

  dt_gen_if #(.SEL_W(4), .DT_W(5)) bus ();

  dt_gen #(
    .SEL_W   (4),
    .DT_W    (5),
    .DT_MIN  (2),
    .DT_STEP (2),
    .SEL_MAX (9)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned exp_dt(input int unsigned s);
    return (s <= 9) ? 2 + 2 * s : 2;
  endfunction

  function automatic void push(input int unsigned gap, input int unsigned dt, input bit hs);
    exp_t x;
    x.gap = gap;
    x.dt  = dt;
    x.hs  = hs;
    sb_q.push_back(x);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Gate-rise monitor: measures the busy both-off run that precedes each gate turn-on.
  always @(negedge clk) begin
    if (rst_n) begin
      chk_eq("gate_overlap", 32'(bus.o_hs & bus.o_ls), 0);
      rise_hs = bus.o_hs && !hs_p;
      rise_ls = bus.o_ls && !ls_p;
      if (rise_hs || rise_ls) begin
        chk_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk_eq("gap", gap_cnt, e.gap);
          chk_eq("o_dt", 32'(bus.o_dt), e.dt);
          chk_eq("gate_side", 32'(rise_hs), 32'(e.hs));
        end
        gap_cnt = 0;
      end else if (bus.o_busy && !bus.o_hs && !bus.o_ls) begin
        gap_cnt++;
      end else begin
        gap_cnt = 0;
      end
      hs_p = bus.o_hs;
      ls_p = bus.o_ls;
    end else begin
      gap_cnt = 0;
      hs_p    = 1'b0;
      ls_p    = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sels[12];
    int          k;
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.i_en  = 1'b0;
    bus.i_pwm = 1'b0;
    bus.i_sel = '0;

    // Reset held with PWM activity: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_pwm = ~bus.i_pwm;
      bus.i_en  = 1'(i % 2);
      chk_eq("rst_hs", 32'(bus.o_hs), 0);
      chk_eq("rst_ls", 32'(bus.o_ls), 0);
      chk_eq("rst_dt", 32'(bus.o_dt), 2);
      chk_eq("rst_busy", 32'(bus.o_busy), 0);
    end

    @(negedge clk);
    bus.i_en  = 1'b1;
    bus.i_pwm = 1'b1;
    bus.i_sel = 4'd0;
    push(2, 2, 1'b1);
    #2 rst_n = 1'b1;
    k = 0;
    while (!bus.o_hs && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk_eq("start_hs", 32'(bus.o_hs), 1);
    cyc(10);

    // Dead-time sweep including out-of-range codes, both edges.
    for (int i = 0; i < 10; i++) sels[i] = i;
    sels[10] = 12;
    sels[11] = 15;
    for (int i = 0; i < 12; i++) begin
      bus.i_sel = 4'(sels[i]);
      bus.i_pwm = 1'b0;
      push(exp_dt(sels[i]), exp_dt(sels[i]), 1'b0);
      cyc(32);
      chk_eq("sweep_ls_on", 32'(bus.o_ls), 1);
      bus.i_pwm = 1'b1;
      push(exp_dt(sels[i]), exp_dt(sels[i]), 1'b1);
      cyc(32);
      chk_eq("sweep_hs_on", 32'(bus.o_hs), 1);
    end

    // Short low pulse inside a long dead time: LS never turns on.
    bus.i_sel = 4'd9;
    bus.i_pwm = 1'b0;
    push(5, 20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("short_ls_off", 32'(bus.o_ls), 0);
      chk_eq("short_hs_off", 32'(bus.o_hs), 0);
    end
    bus.i_pwm = 1'b1;
    @(negedge clk);
    chk_eq("short_hs_back", 32'(bus.o_hs), 1);
    cyc(10);

    // Select change mid-interval only affects the next transition.
    bus.i_sel = 4'd3;
    bus.i_pwm = 1'b0;
    push(8, 8, 1'b0);
    cyc(3);
    bus.i_sel = 4'd7;
    cyc(29);
    bus.i_pwm = 1'b1;
    push(16, 16, 1'b1);
    cyc(32);

    // Enable drop during a dead-time interval.
    bus.i_sel = 4'd2;
    bus.i_pwm = 1'b0;
    cyc(3);
    bus.i_en = 1'b0;
    @(negedge clk);
    chk_eq("en_dt_hs", 32'(bus.o_hs), 0);
    chk_eq("en_dt_ls", 32'(bus.o_ls), 0);
    chk_eq("en_dt_busy", 32'(bus.o_busy), 0);
    chk_eq("en_dt_hold", 32'(bus.o_dt), 6);
    cyc(4);
    bus.i_en = 1'b1;
    push(6, 6, 1'b0);
    cyc(20);
    chk_eq("reen_ls_on", 32'(bus.o_ls), 1);

    // Enable drop while LS is on.
    bus.i_en = 1'b0;
    @(negedge clk);
    chk_eq("en_ls_hs", 32'(bus.o_hs), 0);
    chk_eq("en_ls_ls", 32'(bus.o_ls), 0);
    chk_eq("en_ls_busy", 32'(bus.o_busy), 0);
    cyc(3);
    bus.i_en = 1'b1;
    push(6, 6, 1'b0);
    cyc(20);
    chk_eq("reen2_ls_on", 32'(bus.o_ls), 1);

    cyc(5);
    chk_eq("sb_drain", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
